// File: rtl/mage_pkg.sv
// Shared types and sizes for the hardware-loop sequencer.
// Holds the register-file entry layout and the bound-masking helper.
package mage_pkg;

    localparam int N_LP              = 4;
    localparam int NBIT_LP_IV        = 16;
    localparam int HWLP_RF_SIZE      = 8;
    localparam int LOG2_HWLP_RF_SIZE = 3;
    localparam int NACT_W            = $clog2(N_LP) + 1;

    typedef logic [N_LP-1:0][NBIT_LP_IV-1:0] iv_vec_t;

    typedef struct packed {
        iv_vec_t         iv;
        logic            valid;
        logic [N_LP-1:0] end_cond;
        logic            end_lp;
    } hwlp_entry_t;

    // Zero the bounds of inactive loops; a count of 0 means one loop, and counts above N_LP saturate.
    function automatic iv_vec_t mask_bounds(input iv_vec_t b, input logic [NACT_W-1:0] n);
        logic [NACT_W-1:0] n_eff;
        iv_vec_t           r;
        if (n == {NACT_W{1'b0}}) begin
            n_eff = NACT_W'(1);
        end else if (n > NACT_W'(N_LP)) begin
            n_eff = NACT_W'(N_LP);
        end else begin
            n_eff = n;
        end
        for (int k = 0; k < N_LP; k++) begin
            r[k] = (k < int'(n_eff)) ? b[k] : {NBIT_LP_IV{1'b0}};
        end
        return r;
    endfunction

endpackage

// File: rtl/hwlp_seq_if.sv
// Controller-side bundle for the hardware-loop sequencer.
// The master drives the control and configuration; the slave returns status and the IV register file.
interface hwlp_seq_if;
    import mage_pkg::*;

    logic                                      start_i;
    logic                                      abort_i;
    logic                                      stall_i;
    logic [NACT_W-1:0]                         n_active_lp_i;
    logic [N_LP*NBIT_LP_IV-1:0]                loop_bound_i;
    logic                                      busy_o;
    logic                                      done_o;
    logic [HWLP_RF_SIZE*N_LP*NBIT_LP_IV-1:0]   hwlp_rf_o;
    logic [HWLP_RF_SIZE-1:0]                   hwlp_valid_o;
    logic [HWLP_RF_SIZE*N_LP-1:0]              hwlp_end_condition_o;
    logic [HWLP_RF_SIZE-1:0]                   end_lp_o;

    modport master (
        output start_i, abort_i, stall_i, n_active_lp_i, loop_bound_i,
        input  busy_o, done_o, hwlp_rf_o, hwlp_valid_o, hwlp_end_condition_o, end_lp_o
    );

    modport slave (
        input  start_i, abort_i, stall_i, n_active_lp_i, loop_bound_i,
        output busy_o, done_o, hwlp_rf_o, hwlp_valid_o, hwlp_end_condition_o, end_lp_o
    );

endinterface

// File: rtl/hwlp_nest_cnt.sv
// Cascaded nested-loop counters: loop 0 advances on every enable, and loop k
// advances only when every inner loop sits at its bound.
module hwlp_nest_cnt import mage_pkg::*; (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en,
    input  logic            clr,
    input  iv_vec_t         bound,
    output iv_vec_t         iv,
    output logic [N_LP-1:0] end_condition,
    output logic            last
);

    iv_vec_t         iv_r;
    logic [N_LP-1:0] end_cond_s;
    logic [N_LP-1:0] carry_s;
    logic            acc_s;

    // End-condition flags and the carry chain from the inner loops outward.
    always_comb begin
        end_cond_s = {N_LP{1'b0}};
        carry_s    = {N_LP{1'b0}};
        acc_s      = 1'b1;
        for (int k = 0; k < N_LP; k++) begin
            end_cond_s[k] = (iv_r[k] == bound[k]);
            carry_s[k]    = acc_s;
            acc_s         = acc_s & end_cond_s[k];
        end
    end

    // Counter state; a loop at its bound wraps to 0 instead of incrementing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iv_r <= {(N_LP*NBIT_LP_IV){1'b0}};
        end else if (clr) begin
            iv_r <= {(N_LP*NBIT_LP_IV){1'b0}};
        end else if (en) begin
            for (int k = 0; k < N_LP; k++) begin
                if (carry_s[k]) begin
                    iv_r[k] <= end_cond_s[k] ? {NBIT_LP_IV{1'b0}} : iv_r[k] + NBIT_LP_IV'(1'b1);
                end
            end
        end
    end

    assign iv            = iv_r;
    assign end_condition = end_cond_s;
    assign last          = &end_cond_s;

endmodule

// File: rtl/hwlp_seq.sv
// Nested hardware-loop sequencer: pushes one IV snapshot per cycle into a shift
// register file, drains it after the last iteration and pulses done.
module hwlp_seq import mage_pkg::*; (
    input  logic       clk_i,
    input  logic       rst_i,
    hwlp_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [LOG2_HWLP_RF_SIZE-1:0] DRAIN_LAST = LOG2_HWLP_RF_SIZE'(HWLP_RF_SIZE - 1);
    localparam int ENT_IV_W = N_LP * NBIT_LP_IV;

    state_t                         state_r;
    state_t                         state_nx_s;
    iv_vec_t                        bound_r;
    iv_vec_t                        bound_in_s;
    iv_vec_t                        bound_s;
    iv_vec_t                        iv_s;
    logic [N_LP-1:0]                end_cond_s;
    logic                           last_s;
    logic [LOG2_HWLP_RF_SIZE-1:0]   drain_cnt_r;
    logic                           done_r;
    hwlp_entry_t                    rf_r [HWLP_RF_SIZE];
    hwlp_entry_t                    new_entry_s;
    logic                           start_ok_s;
    logic                           push_s;
    logic                           drain_shift_s;
    logic                           drain_last_s;
    logic                           cnt_clr_s;

    assign bound_in_s = mask_bounds(bus.loop_bound_i, bus.n_active_lp_i);

    // Cycle qualifiers; the start cycle itself pushes the first snapshot, using the live bounds.
    always_comb begin
        start_ok_s    = (state_r == ST_IDLE) && bus.start_i && !bus.abort_i;
        push_s        = !bus.abort_i && !bus.stall_i && (start_ok_s || (state_r == ST_RUN));
        drain_shift_s = !bus.abort_i && !bus.stall_i && (state_r == ST_DRAIN);
        drain_last_s  = drain_shift_s && (drain_cnt_r == DRAIN_LAST);
        cnt_clr_s     = bus.abort_i || ((state_r == ST_IDLE) && !start_ok_s);
        if (state_r == ST_IDLE) begin
            bound_s = bound_in_s;
        end else begin
            bound_s = bound_r;
        end
        new_entry_s = '0;
        if (push_s) begin
            new_entry_s.iv       = iv_s;
            new_entry_s.valid    = 1'b1;
            new_entry_s.end_cond = end_cond_s;
            new_entry_s.end_lp   = last_s;
        end else begin
            new_entry_s = '0;
        end
    end

    hwlp_nest_cnt u_cnt (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en            (push_s),
        .clr           (cnt_clr_s),
        .bound         (bound_s),
        .iv            (iv_s),
        .end_condition (end_cond_s),
        .last          (last_s)
    );

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_nx_s = state_r;
        if (bus.abort_i) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_nx_s = (push_s && last_s) ? ST_DRAIN : ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (push_s && last_s) begin
                        state_nx_s = ST_DRAIN;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_last_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DRAIN;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State, latched configuration, drain counter and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            bound_r     <= {(N_LP*NBIT_LP_IV){1'b0}};
            drain_cnt_r <= {LOG2_HWLP_RF_SIZE{1'b0}};
            done_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            done_r  <= drain_last_s;
            if (start_ok_s) begin
                bound_r <= bound_in_s;
            end
            if (bus.abort_i || (state_r != ST_DRAIN) || drain_last_s) begin
                drain_cnt_r <= {LOG2_HWLP_RF_SIZE{1'b0}};
            end else if (drain_shift_s) begin
                drain_cnt_r <= drain_cnt_r + LOG2_HWLP_RF_SIZE'(1'b1);
            end
        end
    end

    // IV register file: entry 0 is the newest snapshot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < HWLP_RF_SIZE; k++) rf_r[k] <= '0;
        end else if (bus.abort_i) begin
            for (int k = 0; k < HWLP_RF_SIZE; k++) rf_r[k] <= '0;
        end else if (push_s || drain_shift_s) begin
            for (int k = HWLP_RF_SIZE - 1; k > 0; k--) rf_r[k] <= rf_r[k-1];
            rf_r[0] <= new_entry_s;
        end
    end

    // Flatten the register file onto the output buses.
    always_comb begin
        bus.hwlp_rf_o            = '0;
        bus.hwlp_valid_o         = '0;
        bus.hwlp_end_condition_o = '0;
        bus.end_lp_o             = '0;
        for (int k = 0; k < HWLP_RF_SIZE; k++) begin
            bus.hwlp_rf_o[k*ENT_IV_W +: ENT_IV_W]     = rf_r[k].iv;
            bus.hwlp_valid_o[k]                       = rf_r[k].valid;
            bus.hwlp_end_condition_o[k*N_LP +: N_LP]  = rf_r[k].end_cond;
            bus.end_lp_o[k]                           = rf_r[k].end_lp;
        end
    end

    assign bus.busy_o = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign bus.done_o = done_r;

endmodule

// File: tb/tb_hwlp_seq.sv
// Self-checking bench for hwlp_seq: vector table of loop nests with a scoreboard
// of expected snapshots, plus hand-written abort, reset and single-entry sequences.
module tb_hwlp_seq;
    import mage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hwlp_seq_if bus();

    hwlp_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0] iv;
        logic [3:0]  ec;
        logic        el;
    } exp_t;

    typedef struct {
        string       name;
        int          n_act;
        logic [63:0] bnd;
        logic [63:0] stall;
        int          rp1;
        int          rp2;
        int          exp_n;
        int          exp_done;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[6];
    int   checks = 0;
    int   errors = 0;
    int   npop   = 0;
    bit   sb_en  = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; then pop and compare a snapshot if the edge was not stalled.
    task automatic step();
        logic st;
        exp_t e;
        st = bus.stall_i;
        @(posedge clk);
        #1;
        if (sb_en && !st && bus.hwlp_valid_o[0]) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_entry", 512'd1, 512'd0);
            end else begin
                e = sb_q.pop_front();
                npop++;
                check("entry0", {bus.hwlp_rf_o[63:0], bus.hwlp_end_condition_o[3:0], bus.end_lp_o[0]},
                      {e.iv, e.ec, e.el});
            end
        end
    endtask

    task automatic run_nest(input vec_t v);
        int   eb[4];
        int   n_eff;
        int   done_c;
        exp_t e;
        logic [511:0] prev_rf;
        n_eff = (v.n_act == 0) ? 1 : v.n_act;
        for (int k = 0; k < 4; k++) eb[k] = (k < n_eff) ? int'(v.bnd[k*16 +: 16]) : 0;
        for (int i3 = 0; i3 <= eb[3]; i3++)
            for (int i2 = 0; i2 <= eb[2]; i2++)
                for (int i1 = 0; i1 <= eb[1]; i1++)
                    for (int i0 = 0; i0 <= eb[0]; i0++) begin
                        e.iv = {16'(i3), 16'(i2), 16'(i1), 16'(i0)};
                        e.ec = {i3 == eb[3], i2 == eb[2], i1 == eb[1], i0 == eb[0]};
                        e.el = &e.ec;
                        sb_q.push_back(e);
                    end
        npop  = 0;
        sb_en = 1'b1;
        bus.start_i       = 1'b1;
        bus.n_active_lp_i = NACT_W'(v.n_act);
        bus.loop_bound_i  = v.bnd;
        bus.stall_i       = v.stall[0];
        step();
        bus.start_i       = 1'b0;
        bus.loop_bound_i  = {$urandom, $urandom};
        bus.n_active_lp_i = NACT_W'($urandom_range(0, 7));
        done_c = -1;
        for (int c = 1; c < 300; c++) begin
            bus.stall_i = (c < 64) ? v.stall[c] : 1'b0;
            bus.start_i = (c == v.rp1) || (c == v.rp2);
            prev_rf = bus.hwlp_rf_o;
            step();
            if (c == 1) check({v.name, "_busy"}, 512'(bus.busy_o), 512'd1);
            if (bus.stall_i) check({v.name, "_stall_freeze"}, bus.hwlp_rf_o, prev_rf);
            if (bus.done_o) begin
                done_c = c;
                break;
            end
        end
        bus.stall_i = 1'b0;
        bus.start_i = 1'b0;
        check({v.name, "_done_cycle"}, 512'(done_c), 512'(v.exp_done));
        check({v.name, "_n_entries"}, 512'(npop), 512'(v.exp_n));
        check({v.name, "_sb_empty"}, 512'(sb_q.size()), 512'd0);
        check({v.name, "_idle_at_done"}, 512'(bus.busy_o), 512'd0);
        step();
        check({v.name, "_done_pulse"}, 512'(bus.done_o), 512'd0);
        sb_q.delete();
        sb_en = 1'b0;
    endtask

    initial begin
        int done_c;
        vt[0] = '{"nest2",   2, 64'h0000_0000_0002_0001, 64'h0,     -1, -1,  6, 13};
        vt[1] = '{"single",  4, 64'h0000_0000_0000_0000, 64'h0,     -1, -1,  1,  8};
        vt[2] = '{"stall",   1, 64'h0000_0000_0000_0003, 64'hC,     -1, -1,  4, 13};
        vt[3] = '{"repulse", 3, 64'h0000_0001_0001_0002, 64'h4000,   2, 15, 12, 20};
        vt[4] = '{"nact0",   0, 64'h0000_0000_0007_0002, 64'h0,     -1, -1,  3, 10};
        vt[5] = '{"nest4",   4, 64'h0001_0001_0001_0001, 64'h40008, -1, -1, 16, 25};

        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.n_active_lp_i = '0;
        bus.loop_bound_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  512'(bus.busy_o), 512'd0);
        check("rst_done",  512'(bus.done_o), 512'd0);
        check("rst_rf",    bus.hwlp_rf_o, 512'd0);
        check("rst_valid", 512'({bus.hwlp_valid_o, bus.end_lp_o, bus.hwlp_end_condition_o}), 512'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_nest(vt[i]);

        // Single iteration: the lone entry sits at index 3 three cycles later.
        bus.start_i = 1'b1;
        bus.n_active_lp_i = NACT_W'(4);
        bus.loop_bound_i  = 64'd0;
        step();
        bus.start_i = 1'b0;
        repeat (3) step();
        check("single_valid_idx3",  512'(bus.hwlp_valid_o), 512'h08);
        check("single_endlp_idx3",  512'(bus.end_lp_o), 512'h08);
        check("single_endcond_idx3", 512'(bus.hwlp_end_condition_o), 512'h0000_F000);
        done_c = -1;
        for (int c = 4; c < 40; c++) begin
            step();
            if (bus.done_o) begin
                done_c = c;
                break;
            end
        end
        check("single_done_cycle", 512'(done_c), 512'd8);

        // Abort mid-RUN once iv0 reaches 2.
        bus.start_i = 1'b1;
        bus.n_active_lp_i = NACT_W'(1);
        bus.loop_bound_i  = 64'd5;
        step();
        bus.start_i = 1'b0;
        step();
        step();
        check("abort_pre_iv", 512'(bus.hwlp_rf_o[63:0]), 512'd2);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        check("abort_busy",  512'(bus.busy_o), 512'd0);
        check("abort_valid", 512'(bus.hwlp_valid_o), 512'd0);
        check("abort_done",  512'(bus.done_o), 512'd0);
        check("abort_rf",    bus.hwlp_rf_o, 512'd0);
        step();
        check("abort_stay_idle", 512'(bus.busy_o), 512'd0);

        // Start together with abort in IDLE must not start.
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        check("start_abort_busy", 512'(bus.busy_o), 512'd0);
        check("start_abort_valid", 512'(bus.hwlp_valid_o), 512'd0);

        run_nest(vt[0]);

        // Asynchronous reset in the middle of DRAIN.
        bus.start_i = 1'b1;
        bus.n_active_lp_i = NACT_W'(1);
        bus.loop_bound_i  = 64'd1;
        step();
        bus.start_i = 1'b0;
        repeat (4) step();
        check("pre_rst_busy", 512'(bus.busy_o), 512'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy",  512'(bus.busy_o), 512'd0);
        check("async_rst_rf",    bus.hwlp_rf_o, 512'd0);
        check("async_rst_flags", 512'({bus.hwlp_valid_o, bus.end_lp_o, bus.hwlp_end_condition_o, bus.done_o}), 512'd0);
        @(negedge clk);
        rst = 1'b0;
        run_nest(vt[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
